// File: rtl/alu_cmd_sequencer.sv
// Issue stage in front of the 8-bit ALU: buffers (A, B, opcode) commands in a FIFO,
// drives the ALU from registers and returns each captured result over valid/ready.
module alu_cmd_sequencer #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [WIDTH-1:0]           cmd_a,
  input  logic [WIDTH-1:0]           cmd_b,
  input  logic [OPW-1:0]             cmd_s,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [OPW-1:0]             alu_s,
  input  logic [WIDTH-1:0]           alu_y,
  input  logic                       alu_carry,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH-1:0]           res_y,
  output logic                       res_carry,
  output logic [OPW-1:0]             res_s,
  output logic [7:0]                 res_tag,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t          state;
  state_t          next_state;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [OPW-1:0]   mem_s [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [7:0]       tag;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  // Ready comes from the registered count only, so a same-cycle pop never frees a full FIFO early.
  assign fifo_empty = (count == '0);
  assign cmd_ready  = (count != FULL_COUNT);
  assign push       = cmd_valid & cmd_ready;
  assign fifo_count = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: next_state = HOLD;
      HOLD: begin
        if (res_ready) begin
          pop        = !fifo_empty;
          next_state = fifo_empty ? IDLE : EXEC;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= cmd_a;
      mem_b[wr_ptr] <= cmd_b;
      mem_s[wr_ptr] <= cmd_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // EXEC lasts one cycle: the ALU settles on the registered operands and is sampled at its end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      res_valid <= 1'b0;
      res_y     <= '0;
      res_carry <= 1'b0;
      res_s     <= '0;
      res_tag   <= '0;
      tag       <= '0;
    end else begin
      if (pop) begin
        alu_a <= mem_a[rd_ptr];
        alu_b <= mem_b[rd_ptr];
        alu_s <= mem_s[rd_ptr];
      end
      if (state == EXEC) begin
        res_y     <= alu_y;
        res_carry <= alu_carry;
        res_s     <= alu_s;
        res_tag   <= tag;
        tag       <= tag + 8'd1;
        res_valid <= 1'b1;
      end else if (state == HOLD && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with an adder stub standing in for the ALU.
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [2:0] cmd_s;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_s;
  logic [7:0] alu_y;
  logic       alu_carry;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_y;
  logic       res_carry;
  logic [2:0] res_s;
  logic [7:0] res_tag;
  logic [2:0] fifo_count;

  typedef struct {
    logic [7:0] y;
    logic       c;
    logic [2:0] s;
    logic [7:0] tag;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] seen_tags[$];
  int         model_tag;
  int         errors;
  int         checks;

  alu_cmd_sequencer #(.WIDTH(8), .OPW(3), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_y(alu_y), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_carry(res_carry), .res_s(res_s), .res_tag(res_tag),
    .fifo_count(fifo_count)
  );

  assign {alu_carry, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
    end
  endtask

  // Commands are logged on the cycle they are accepted; results are checked as they are handed off.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      seen_tags.push_back(res_tag);
      if (sb.size() == 0) begin
        checkOutput("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sb_res_y", res_y, e.y);
        checkOutput("sb_res_carry", res_carry, e.c);
        checkOutput("sb_res_s", res_s, e.s);
        checkOutput("sb_res_tag", res_tag, e.tag);
      end
    end
    if (rst_n && cmd_valid && cmd_ready) begin
      exp_t e;
      logic [8:0] sum;
      sum   = {1'b0, cmd_a} + {1'b0, cmd_b};
      e.y   = sum[7:0];
      e.c   = sum[8];
      e.s   = cmd_s;
      e.tag = model_tag[7:0];
      model_tag = (model_tag + 1) % 256;
      sb.push_back(e);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    logic accepted;
    accepted  = 1'b0;
    cmd_a     = a;
    cmd_b     = b;
    cmd_s     = s;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      accepted = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!accepted) checkOutput("push_timeout", 0, 1);
  endtask

  task automatic clearModel;
    sb.delete();
    seen_tags.delete();
    model_tag = 0;
  endtask

  task automatic resetDut;
    cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    clearModel();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 200 && sb.size() > 0; i++) tick();
    repeat (3) tick();
    checkOutput("drain_empty", sb.size(), 0);
    checkOutput("drain_idle_valid", res_valid, 0);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    model_tag = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_s     = '0;
    res_ready = 1'b0;

    #1;
    checkOutput("rst_fifo_count", fifo_count, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_res_tag", res_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] single command latency");
    res_ready = 1'b1;
    applyStimulus(8'd10, 8'd10, 3'b000);
    checkOutput("lat_e0_valid", res_valid, 0);
    tick();
    checkOutput("lat_e1_alu_a", alu_a, 10);
    checkOutput("lat_e1_alu_b", alu_b, 10);
    checkOutput("lat_e1_valid", res_valid, 0);
    tick();
    checkOutput("lat_e2_valid", res_valid, 1);
    checkOutput("lat_e2_y", res_y, 20);
    checkOutput("lat_e2_carry", res_carry, 0);
    checkOutput("lat_e2_tag", res_tag, 0);
    tick();
    checkOutput("lat_e3_valid", res_valid, 0);

    $display("[TB] carry capture");
    applyStimulus(8'd200, 8'd100, 3'b011);
    tick();
    tick();
    checkOutput("carry_valid", res_valid, 1);
    checkOutput("carry_y", res_y, 44);
    checkOutput("carry_c", res_carry, 1);
    checkOutput("carry_s", res_s, 3);
    tick();

    $display("[TB] backpressure, full FIFO and stall hold");
    resetDut();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(8'(i * 20 + 5), 8'(i * 3 + 7), 3'(i));
    cmd_a     = 8'd105;
    cmd_b     = 8'd22;
    cmd_s     = 3'd5;
    cmd_valid = 1'b1;
    checkOutput("full_count", fifo_count, 4);
    checkOutput("full_ready", cmd_ready, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_valid", res_valid, 1);
      checkOutput("stall_y", res_y, 12);
      checkOutput("stall_s", res_s, 0);
      checkOutput("stall_tag", res_tag, 0);
      checkOutput("stall_full_ready", cmd_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    checkOutput("release_ready", cmd_ready, 1);
    checkOutput("release_count", fifo_count, 3);
    checkOutput("release_exec_valid", res_valid, 0);
    tick();
    cmd_valid = 1'b0;
    checkOutput("order_valid_1", res_valid, 1);
    checkOutput("order_tag_1", res_tag, 1);
    for (int k = 2; k <= 5; k++) begin
      tick();
      checkOutput("order_gap", res_valid, 0);
      tick();
      checkOutput("order_valid", res_valid, 1);
      checkOutput("order_tag", res_tag, k);
    end
    drain();

    $display("[TB] reset mid-operation");
    resetDut();
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(8'(i + 1), 8'(i + 2), 3'(i));
    checkOutput("mid_pre_count", fifo_count, 3);
    checkOutput("mid_pre_exec", res_valid, 0);
    #2;
    rst_n = 1'b0;
    clearModel();
    #1;
    checkOutput("mid_count", fifo_count, 0);
    checkOutput("mid_valid", res_valid, 0);
    checkOutput("mid_ready", cmd_ready, 1);
    checkOutput("mid_alu_a", alu_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_valid", res_valid, 0);
    applyStimulus(8'd7, 8'd8, 3'd2);
    tick();
    tick();
    checkOutput("post_rst_res_valid", res_valid, 1);
    checkOutput("post_rst_tag", res_tag, 0);
    checkOutput("post_rst_y", res_y, 15);
    drain();

    $display("[TB] tag wrap");
    resetDut();
    res_ready = 1'b1;
    for (int i = 0; i < 257; i++) applyStimulus(8'($urandom), 8'($urandom), 3'($urandom));
    drain();
    checkOutput("wrap_count", seen_tags.size(), 257);
    if (seen_tags.size() >= 257) begin
      checkOutput("wrap_tag_255", seen_tags[255], 255);
      checkOutput("wrap_tag_256", seen_tags[256], 0);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      cmd_s     = 3'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
